store_align_buf: RTL and testbench
==================================

// Module: store_align_buf
// PURPOSE
//  Store-side counterpart of the load extension path: takes st.b/st.h/st.w requests from MEM,
//  aligns data into byte lanes, builds byte write-enables, flags misaligned stores (ALE).
//  Queues legal stores in a small FIFO and drains them to the data RAM port over req/ack.
//  Sits between the MEM stage and the data RAM; feeds the load path's hazard check.
// PARAMETERS
//  DEPTH   2   FIFO entries; power of two, >= 2
//  AW      32  address width; RAM address is word-aligned (addr[1:0] forced 0)
// PORTS
//  clk          in   1   core clock
//  rst_n        in   1   asynchronous active-low reset
//  st_valid     in   1   store request valid
//  st_ready     out  1   request accepted when st_valid && st_ready
//  st_addr      in   AW  byte address
//  st_data      in   32  store data, operand in low bits
//  st_op        in   2   `RAM_ST_B / `RAM_ST_H / `RAM_ST_W (2'b11 treated as W)
//  ale          out  1   one-cycle misaligned-store pulse
//  ale_badv     out  AW  faulting address, valid while ale=1
//  ram_req      out  1   head entry valid toward data RAM
//  ram_ack      in   1   RAM accepted head entry this cycle
//  ram_addr     out  AW  word address of head entry
//  ram_we       out  4   byte enables of head entry
//  ram_wdata    out  32  lane-aligned data of head entry
//  ld_addr      in   AW  load address probed by MEM
//  ld_hit       out  1   a pending entry's word address equals ld_addr word address
//  buf_empty    out  1   no pending stores
// BEHAVIOUR
//  - Reset: pointers/count 0, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, ale=0,
//    ale_badv=0, buf_empty=1, st_ready=1. Reset mid-drain discards all entries.
//  - st_ready = !full (combinational from count); no bypass, no push when full.
//  - Misaligned: H with addr[0]=1, W with addr[1:0]!=0. On handshake: not enqueued,
//    ale=1 and ale_badv=st_addr next cycle, ale=0 cycle after unless another fault.
//  - Lane alignment, off = st_addr[1:0]:
//    B: wdata={4{data[7:0]}},  we=4'b0001<<off
//    H: wdata={2{data[15:0]}}, we=4'b0011<<off (off in {0,2})
//    W: wdata=data,            we=4'b1111
//  - Entry stored = {addr[AW-1:2],2'b00, we, wdata}; computed at push time.
//  - Drain: ram_req = !buf_empty; ram_addr/we/wdata = head entry, stable until ram_ack.
//    Pop on ram_req && ram_ack. When empty ram_we=0 and ram_wdata/ram_addr hold 0.
//  - Latency: store pushed in cycle N → ram_req=1 in N+1 (registered FIFO state).
//  - Simultaneous push+pop: count unchanged, both pointers advance; allowed whenever
//    not full at cycle start. Full + ack frees a slot only from the next cycle.
//  - Pointers wrap modulo DEPTH; count 0..DEPTH, full = (count==DEPTH).
//  - ld_hit: combinational OR over valid entries of (entry_addr[AW-1:2]==ld_addr[AW-1:2]);
//    entry being popped this cycle still counts.
//  - ram_ack while ram_req=0 is ignored.
// STRUCTURE
//  - defines.vh: `RAM_ST_B/H/W codes beside the existing load-extension codes.
//  - Sub-module st_lane_align (combinational op/offset → we, wdata, misalign);
//    FIFO, pointers, ALE register, hit compare in the top module.
// TESTING
//  1 st.w addr=0x100 data=0xDEADBEEF, ack next cycle → ram_req 1 cycle later,
//    ram_addr=0x100 we=4'b1111 wdata=0xDEADBEEF; buf_empty=1 after ack.
//  2 st.b addr=0x203 data=0x5A → ram_addr=0x200 we=4'b1000 wdata=0x5A5A5A5A;
//    st.h addr=0x202 data=0x1234 → we=4'b1100 wdata=0x12341234.
//  3 st.h addr=0x301, then st.w addr=0x302 → ale pulse each, ale_badv=0x301/0x302,
//    no ram_req, buf_empty stays 1.
//  4 ack held 0, push 3 stores (DEPTH=2) → st_ready=0 after 2nd; ack once → 3rd
//    accepted next cycle; drain order matches push order.
//  5 entry pending at 0x400; ld_addr=0x403 → ld_hit=1; ld_addr=0x404 → ld_hit=0.
//  6 rst_n low with 2 pending stores → all outputs reset values immediately, no further ram_req.

Source files
------------

// File: rtl/store_align_buf_pkg.sv
// Shared store-op encodings and datapath widths for the store alignment buffer.
package store_align_buf_pkg;

    typedef enum logic [1:0] {
        RAM_ST_B  = 2'b00,
        RAM_ST_H  = 2'b01,
        RAM_ST_W  = 2'b10,
        RAM_ST_WX = 2'b11
    } st_op_e;

    localparam int DATA_W = 32;
    localparam int WE_W   = 4;

endpackage

// File: rtl/store_align_buf_st_lane_align.sv
// Combinational lane steering: replicates the operand across byte lanes and builds
// the byte write-enable mask for the given op and address offset.
import store_align_buf_pkg::*;

module st_lane_align (
    input  logic [1:0]        op_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [WE_W-1:0]   we_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misalign_o
);

    always_comb begin
        we_o       = '0;
        wdata_o    = data_i;
        misalign_o = 1'b0;
        case (st_op_e'(op_i))
            RAM_ST_B: begin
                we_o    = 4'b0001 << off_i;
                wdata_o = {4{data_i[7:0]}};
            end
            RAM_ST_H: begin
                we_o       = 4'b0011 << off_i;
                wdata_o    = {2{data_i[15:0]}};
                misalign_o = off_i[0];
            end
            // The spare encoding behaves as a full word store.
            default: begin
                we_o       = 4'b1111;
                wdata_o    = data_i;
                misalign_o = (off_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_align_buf.sv
// Store buffer between MEM and the data RAM: aligns stores, traps misaligned ones,
// queues legal ones in a small FIFO and drains them over a req/ack port.
import store_align_buf_pkg::*;

module store_align_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [AW-1:0]     st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_op,
    output logic              ale,
    output logic [AW-1:0]     ale_badv,
    output logic              ram_req,
    input  logic              ram_ack,
    output logic [AW-1:0]     ram_addr,
    output logic [WE_W-1:0]   ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [AW-1:0]     ld_addr,
    output logic              ld_hit,
    output logic              buf_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-3:0]     ent_addr_q  [DEPTH];
    logic [WE_W-1:0]   ent_we_q    [DEPTH];
    logic [DATA_W-1:0] ent_wdata_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ale_q;
    logic [AW-1:0]     ale_badv_q;

    logic [WE_W-1:0]   al_we;
    logic [DATA_W-1:0] al_wdata;
    logic              al_misalign;
    logic              full, push, pop, fault;
    logic [1:0]        unused_ld_lsb;

    st_lane_align u_align (
        .op_i       (st_op),
        .off_i      (st_addr[1:0]),
        .data_i     (st_data),
        .we_o       (al_we),
        .wdata_o    (al_wdata),
        .misalign_o (al_misalign)
    );

    assign full      = (count_q == CW'(DEPTH));
    assign buf_empty = (count_q == '0);
    assign st_ready  = !full;
    assign push      = st_valid && !full && !al_misalign;
    assign fault     = st_valid && !full && al_misalign;
    assign pop       = ram_req && ram_ack;

    assign ram_req   = !buf_empty;
    assign ram_addr  = buf_empty ? '0 : {ent_addr_q[rd_ptr_q], 2'b00};
    assign ram_we    = buf_empty ? '0 : ent_we_q[rd_ptr_q];
    assign ram_wdata = buf_empty ? '0 : ent_wdata_q[rd_ptr_q];
    assign ale       = ale_q;
    assign ale_badv  = ale_badv_q;

    assign unused_ld_lsb = ld_addr[1:0];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] rel;
            rel = PW'(i) - rd_ptr_q;
            if (({1'b0, rel} < count_q) && (ent_addr_q[i] == ld_addr[AW-1:2]))
                ld_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ale_q      <= 1'b0;
            ale_badv_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i]  <= '0;
                ent_we_q[i]    <= '0;
                ent_wdata_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            ale_q      <= fault;
            ale_badv_q <= fault ? st_addr : '0;
            if (push) begin
                ent_addr_q[wr_ptr_q]  <= st_addr[AW-1:2];
                ent_we_q[wr_ptr_q]    <= al_we;
                ent_wdata_q[wr_ptr_q] <= al_wdata;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_store_align_buf.sv
// Directed bench for store_align_buf: alignment, ALE, FIFO full/drain order, load hit, reset.
module tb_store_align_buf;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_op;
    logic        ale;
    logic [31:0] ale_badv;
    logic        ram_req;
    logic        ram_ack;
    logic [31:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        buf_empty;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [1:0] OP_B = 2'b00;
    localparam logic [1:0] OP_H = 2'b01;
    localparam logic [1:0] OP_W = 2'b10;

    store_align_buf #(.DEPTH(2), .AW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_op     (st_op),
        .ale       (ale),
        .ale_badv  (ale_badv),
        .ram_req   (ram_req),
        .ram_ack   (ram_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .buf_empty (buf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_st(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = data;
    endtask

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_op    = OP_W;
        ram_ack  = 1'b0;
        ld_addr  = '0;

        // Reset values
        #12;
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_ram_req", 32'(ram_req), 32'd0);
        check("rst_buf_empty", 32'(buf_empty), 32'd1);
        check("rst_ale", 32'(ale), 32'd0);
        check("rst_ale_badv", ale_badv, 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        rst_n = 1'b1;

        // 1: word store, one-cycle latency to ram_req, ack drains it
        tick();
        drive_st(OP_W, 32'h100, 32'hDEADBEEF);
        #1;
        check("t1_ready", 32'(st_ready), 32'd1);
        check("t1_req_same_cycle", 32'(ram_req), 32'd0);
        tick();
        st_valid = 1'b0;
        check("t1_req", 32'(ram_req), 32'd1);
        check("t1_addr", ram_addr, 32'h100);
        check("t1_we", 32'(ram_we), 32'hF);
        check("t1_wdata", ram_wdata, 32'hDEADBEEF);
        check("t1_not_empty", 32'(buf_empty), 32'd0);
        ram_ack = 1'b1;
        tick();
        check("t1_empty", 32'(buf_empty), 32'd1);
        check("t1_req_done", 32'(ram_req), 32'd0);
        check("t1_we_idle", 32'(ram_we), 32'd0);
        check("t1_wdata_idle", ram_wdata, 32'd0);
        // stray ack while empty must not disturb the count
        tick();
        ram_ack = 1'b0;
        check("t1_stray_ack_empty", 32'(buf_empty), 32'd1);
        check("t1_stray_ack_ready", 32'(st_ready), 32'd1);

        // 2: byte and half stores into upper lanes
        drive_st(OP_B, 32'h203, 32'h0000005A);
        tick();
        drive_st(OP_H, 32'h202, 32'h00001234);
        #1;
        check("t2b_addr", ram_addr, 32'h200);
        check("t2b_we", 32'(ram_we), 32'b1000);
        check("t2b_wdata", ram_wdata, 32'h5A5A5A5A);
        tick();
        st_valid = 1'b0;
        check("t2_full", 32'(st_ready), 32'd0);
        check("t2b_hold_we", 32'(ram_we), 32'b1000);
        ram_ack = 1'b1;
        ld_addr = 32'h200;
        #1;
        check("t2_hit_popping", 32'(ld_hit), 32'd1);
        tick();
        check("t2h_addr", ram_addr, 32'h200);
        check("t2h_we", 32'(ram_we), 32'b1100);
        check("t2h_wdata", ram_wdata, 32'h12341234);
        tick();
        ram_ack = 1'b0;
        check("t2_empty", 32'(buf_empty), 32'd1);

        // 3: misaligned half and word stores raise ALE and are dropped
        drive_st(OP_H, 32'h301, 32'h1);
        #1;
        check("t3_ready", 32'(st_ready), 32'd1);
        tick();
        drive_st(OP_W, 32'h302, 32'h2);
        check("t3_ale_h", 32'(ale), 32'd1);
        check("t3_badv_h", ale_badv, 32'h301);
        check("t3_noreq_h", 32'(ram_req), 32'd0);
        tick();
        st_valid = 1'b0;
        check("t3_ale_w", 32'(ale), 32'd1);
        check("t3_badv_w", ale_badv, 32'h302);
        check("t3_empty_w", 32'(buf_empty), 32'd1);
        tick();
        check("t3_ale_clear", 32'(ale), 32'd0);
        check("t3_noreq", 32'(ram_req), 32'd0);
        check("t3_empty", 32'(buf_empty), 32'd1);

        // 4: fill to DEPTH, back-pressure, then drain in push order
        drive_st(OP_W, 32'h500, 32'h1);
        tick();
        drive_st(OP_W, 32'h504, 32'h2);
        check("t4_ready_1", 32'(st_ready), 32'd1);
        tick();
        drive_st(OP_W, 32'h508, 32'h3);
        check("t4_ready_full", 32'(st_ready), 32'd0);
        tick();
        check("t4_still_full", 32'(st_ready), 32'd0);
        check("t4_head0", ram_addr, 32'h500);
        ld_addr = 32'h506;
        #1;
        check("t4_hit_second", 32'(ld_hit), 32'd1);
        ld_addr = 32'h508;
        #1;
        check("t4_miss_third", 32'(ld_hit), 32'd0);
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        check("t4_ready_freed", 32'(st_ready), 32'd1);
        check("t4_head1", ram_addr, 32'h504);
        check("t4_head1_data", ram_wdata, 32'h2);
        tick();
        st_valid = 1'b0;
        check("t4_refull", 32'(st_ready), 32'd0);
        check("t4_head1_hold", ram_addr, 32'h504);
        ram_ack = 1'b1;
        tick();
        check("t4_head2", ram_addr, 32'h508);
        check("t4_head2_data", ram_wdata, 32'h3);
        tick();
        ram_ack = 1'b0;
        check("t4_empty", 32'(buf_empty), 32'd1);

        // 5: load hazard probe against a pending entry
        drive_st(OP_W, 32'h400, 32'h77);
        tick();
        drive_st(OP_W, 32'h40C, 32'h88);
        ld_addr = 32'h403;
        #1;
        check("t5_hit", 32'(ld_hit), 32'd1);
        ld_addr = 32'h404;
        #1;
        check("t5_miss", 32'(ld_hit), 32'd0);
        tick();
        st_valid = 1'b0;
        check("t5_two_pending", 32'(st_ready), 32'd0);
        check("t5_req", 32'(ram_req), 32'd1);

        // 6: asynchronous reset mid-drain discards everything
        ld_addr = 32'h400;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req", 32'(ram_req), 32'd0);
        check("t6_empty", 32'(buf_empty), 32'd1);
        check("t6_ready", 32'(st_ready), 32'd1);
        check("t6_we", 32'(ram_we), 32'd0);
        check("t6_addr", ram_addr, 32'd0);
        check("t6_wdata", ram_wdata, 32'd0);
        check("t6_hit", 32'(ld_hit), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_req_after", 32'(ram_req), 32'd0);
        check("t6_empty_after", 32'(buf_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
